ddrx_refresh_timer: RTL and testbench

// Refresh scheduler for the DDRx controller. It sits directly downstream of the NASTI-Lite

---
 rtl/ddrx_refresh_timer.sv | 78 +++++++
 tb/tb_ddrx_refresh_timer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ddrx_refresh_timer.sv
// Refresh scheduler: counts tREFI intervals into a bounded REF debt, requests each owed REF
// over req/ack, and holds the bank busy for tRFC after every grant.
module ddrx_refresh_timer #(
  parameter  int TREFI_W       = 16,
  parameter  int TRFC_W        = 10,
  parameter  int MAX_DEBT      = 8,
  parameter  int URGENT_THRESH = 6,
  localparam int DW            = $clog2(MAX_DEBT+1)
) (
  input  logic               mc_clk,
  input  logic               mc_aresetn,
  input  logic               cfg_ref_en,
  input  logic [TREFI_W-1:0] cfg_trefi,
  input  logic [TRFC_W-1:0]  cfg_trfc,
  output logic               ref_req,
  input  logic               ref_ack,
  output logic               ref_busy,
  output logic               ref_urgent,
  output logic [DW-1:0]      ref_debt,
  output logic               err_overflow
);

  typedef enum logic [1:0] {IDLE, REQ, TRFC} state_t;

  state_t             state;
  logic [TREFI_W-1:0] cnt;
  logic [TRFC_W-1:0]  trfc_cnt;
  logic [DW-1:0]      debt;
  logic               err;
  logic               run, tick, grant;
  logic [TRFC_W-1:0]  trfc_load;

  // >= rather than == so that shrinking cfg_trefi mid-interval ticks immediately
  assign run       = cfg_ref_en && (cfg_trefi != '0);
  assign tick      = run && (cnt >= cfg_trefi - TREFI_W'(1));
  assign grant     = (state == REQ) && ref_ack;
  assign trfc_load = (cfg_trfc == '0) ? TRFC_W'(1) : cfg_trfc;

  always_ff @(posedge mc_clk) begin
    if (!mc_aresetn) begin
      cnt      <= '0;
      debt     <= '0;
      err      <= 1'b0;
      trfc_cnt <= '0;
      state    <= IDLE;
    end else begin
      cnt <= (!run || tick) ? '0 : cnt + TREFI_W'(1);

      // a tick landing on a full debt is lost and flagged
      if (tick && !grant) begin
        if (debt == DW'(MAX_DEBT)) err  <= 1'b1;
        else                       debt <= debt + DW'(1);
      end else if (grant && !tick) begin
        debt <= debt - DW'(1);
      end

      case (state)
        IDLE: if (debt != '0) state <= REQ;
        REQ: if (ref_ack) begin
          state    <= TRFC;
          trfc_cnt <= trfc_load;
        end
        TRFC: begin
          if (trfc_cnt == TRFC_W'(1)) state <= IDLE;
          trfc_cnt <= trfc_cnt - TRFC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ref_req      = (state == REQ);
  assign ref_busy     = (state == TRFC);
  assign ref_debt     = debt;
  assign ref_urgent   = (debt >= DW'(URGENT_THRESH));
  assign err_overflow = err;

endmodule

// File: tb/tb_ddrx_refresh_timer.sv
// Directed bench for ddrx_refresh_timer; cycle k is the k-th cycle after the last reset edge.
module tb_ddrx_refresh_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] trefi;
  logic [9:0]  trfc;
  logic        ack;
  logic        req, busy, urgent, err;
  logic [3:0]  debt;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ddrx_refresh_timer dut (
    .mc_clk      (clk),
    .mc_aresetn  (rst_n),
    .cfg_ref_en  (en),
    .cfg_trefi   (trefi),
    .cfg_trfc    (trfc),
    .ref_req     (req),
    .ref_ack     (ack),
    .ref_busy    (busy),
    .ref_urgent  (urgent),
    .ref_debt    (debt),
    .err_overflow(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one reset edge, then release; returns in cycle 0
  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic seen_req;
    en = 1'b0; trefi = '0; trfc = '0; ack = 1'b0; rst_n = 1'b0;
    step(2);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_debt", debt, 0);
    chk("rst_urgent", urgent, 0);
    chk("rst_err", err, 0);

    // 1: basic tick/req/grant/blanking timeline
    en = 1'b1; trefi = 16'd10; trfc = 10'd4; ack = 1'b1;
    do_reset();
    step(9);  chk("t1_c9_debt", debt, 0);
    step(1);  chk("t1_c10_debt", debt, 1); chk("t1_c10_req", req, 0);
    step(1);  chk("t1_c11_req", req, 1);   chk("t1_c11_busy", busy, 0);
    step(1);  chk("t1_c12_busy", busy, 1); chk("t1_c12_debt", debt, 0); chk("t1_c12_req", req, 0);
    step(3);  chk("t1_c15_busy", busy, 1);
    step(1);  chk("t1_c16_busy", busy, 0); chk("t1_c16_req", req, 0);

    // 2: accumulate to the debt limit, then overflow
    ack = 1'b0; trefi = 16'd10; trfc = 10'd4;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(10);
      chk($sformatf("t2_debt%0d", k), debt, k);
      chk($sformatf("t2_urg%0d", k), urgent, (k >= 6) ? 1 : 0);
      chk($sformatf("t2_err%0d", k), err, 0);
    end
    step(10);
    chk("t2_ovf_debt", debt, 8); chk("t2_ovf_err", err, 1); chk("t2_ovf_req", req, 1);

    // 3: drain with trfc=0 (one busy cycle per grant), ticks stopped; cycle 90 here
    en = 1'b0; trfc = 10'd0; ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("t3_busy%0d", k), busy, 1);
      chk($sformatf("t3_debt%0d", k), debt, 8 - k);
      step(1);
      chk($sformatf("t3_idle%0d", k), busy, 0);
      step(1);
      chk($sformatf("t3_req%0d", k), req, (k < 8) ? 1 : 0);
    end
    step(5);
    chk("t3_req_end", req, 0); chk("t3_debt_end", debt, 0); chk("t3_err_sticky", err, 1);
    do_reset();
    chk("t3_err_cleared", err, 0);

    // 4a: grant on the same edge as a tick at debt 3
    en = 1'b1; trefi = 16'd10; trfc = 10'd4; ack = 1'b0;
    do_reset();
    step(39); chk("t4_c39_debt", debt, 3); chk("t4_c39_req", req, 1);
    ack = 1'b1;
    step(1);  chk("t4_c40_debt", debt, 3); chk("t4_c40_busy", busy, 1);
    ack = 1'b0;

    // 4b: shrink trefi mid-count
    trefi = 16'd100;
    do_reset();
    step(50); chk("t4_c50_debt", debt, 0);
    trefi = 16'd5;
    step(1);  chk("t4_c51_debt", debt, 1);
    step(4);  chk("t4_c55_debt", debt, 1);
    step(1);  chk("t4_c56_debt", debt, 2);

    // 5: reset during blanking with debt 4
    en = 1'b1; trefi = 16'd1; trfc = 10'd20; ack = 1'b0;
    do_reset();
    step(5);  chk("t5_c5_debt", debt, 5); chk("t5_c5_req", req, 1);
    en = 1'b0; ack = 1'b1;
    step(1);  chk("t5_c6_busy", busy, 1); chk("t5_c6_debt", debt, 4);
    ack = 1'b0; rst_n = 1'b0;
    step(1);
    chk("t5_rst_busy", busy, 0); chk("t5_rst_req", req, 0);
    chk("t5_rst_debt", debt, 0); chk("t5_rst_err", err, 0);
    en = 1'b1; trefi = 16'd10; rst_n = 1'b1;
    step(9);  chk("t5_c9_debt", debt, 0);
    step(1);  chk("t5_c10_debt", debt, 1);

    // 6: ticking disabled by trefi=0, then by en=0
    en = 1'b1; trefi = 16'd0; ack = 1'b1;
    do_reset();
    seen_req = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      seen_req |= req;
    end
    chk("t6_trefi0_req", seen_req, 0); chk("t6_trefi0_debt", debt, 0);
    en = 1'b0; trefi = 16'd10;
    do_reset();
    seen_req = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      seen_req |= req;
    end
    chk("t6_en0_req", seen_req, 0); chk("t6_en0_debt", debt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
